lut_neuron_table_loader: RTL

- Runtime-programmable LogicNets neuron truth table: the write side for the fixed distributed-ROM neurons (6-bit input code to 2-bit output code).
- Accepts a valid/ready stream of table entries in ascending input-code order and stores them in a register-based table.
- Once the table is armed, serves single-cycle registered lookups, so on-chip neuron tables can be reloaded without resynthesis.
- Sits between the configuration stream interconnect and a layer's neuron slot.

---
 rtl/lut_neuron_pkg.sv | 19 +
 rtl/lut_neuron_table_ram.sv | 52 +++++
 rtl/lut_neuron_table_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the LogicNets neuron table loader: controller
// states, default code widths and the table-depth helper.
package lut_neuron_pkg;

    localparam int DEF_IN_BITS  = 6;
    localparam int DEF_OUT_BITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        ERR   = 2'd3
    } state_t;

    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_table_ram.sv
// Register-array neuron truth table: one write port, one registered lookup
// port. With LUT_TABLE_READBACK_EN defined, a second asynchronous read port
// feeds the readback stream.
module lut_neuron_table_ram
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic                rd_en,
    input  logic                rd_clr,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
`ifdef LUT_TABLE_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic [OUT_BITS-1:0] rb_data
`endif
);

    localparam int DEPTH = table_depth(IN_BITS);

    logic [OUT_BITS-1:0] mem [DEPTH];

    // Table storage: cleared on reset so an aborted load never leaves stale codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered lookup; forced to zero while the table is not armed, held otherwise.
    always_ff @(posedge clk) begin
        if (rst || rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

`ifdef LUT_TABLE_READBACK_EN
    assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Runtime-programmable LogicNets neuron truth table. Entries arrive on a
// valid/ready stream in ascending code order; once all 2**IN_BITS entries
// land with s_last on the final one, the table is armed and serves
// single-cycle registered lookups.
// Optional build macro: LUT_TABLE_READBACK_EN (adds a table readback stream).
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// LOAD  | accepting entries, wr_addr points at the next code
// ARMED | table complete, lookups (and readback) served
// ERR   | last load was malformed, waiting for load_start
module lut_neuron_table_loader
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [OUT_BITS-1:0] s_data,
    input  logic                s_last,
    input  logic                lk_valid,
    input  logic [IN_BITS-1:0]  lk_addr,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                armed,
    output logic                load_err
`ifdef LUT_TABLE_READBACK_EN
    ,
    input  logic                rb_start,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_BITS-1:0] m_data,
    output logic                m_last
`endif
);

    localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(table_depth(IN_BITS) - 1);

    state_t              state, state_nxt;
    logic [IN_BITS-1:0]  wr_addr, wr_addr_nxt;
    logic                tbl_we;
    logic                at_last;

    assign at_last  = (wr_addr == LAST_ADDR);
    assign s_ready  = (state == LOAD);
    assign armed    = (state == ARMED);
    assign load_err = (state == ERR);

    // Controller state and write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_addr <= '0;
        end else begin
            state   <= state_nxt;
            wr_addr <= wr_addr_nxt;
        end
    end

    // Next-state logic; load_start always wins over a same-cycle handshake.
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        tbl_we      = 1'b0;
        case (state)
            LOAD: begin
                if (load_start) begin
                    wr_addr_nxt = '0;
                end else if (s_valid) begin
                    tbl_we      = 1'b1;
                    wr_addr_nxt = wr_addr + 1'b1;
                    if (s_last || at_last) begin
                        state_nxt = (s_last && at_last) ? ARMED : ERR;
                    end
                end
            end
            IDLE, ARMED, ERR: begin
                if (load_start) begin
                    state_nxt   = LOAD;
                    wr_addr_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lookup result valid follows an accepted request by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= armed && lk_valid;
        end
    end

`ifdef LUT_TABLE_READBACK_EN
    logic               rb_active;
    logic [IN_BITS-1:0] rb_addr;

    // Readback pointer: runs only while armed, aborted by any new load.
    always_ff @(posedge clk) begin
        if (rst || !armed || load_start) begin
            rb_active <= 1'b0;
            rb_addr   <= '0;
        end else if (!rb_active) begin
            if (rb_start) begin
                rb_active <= 1'b1;
                rb_addr   <= '0;
            end
        end else if (m_ready) begin
            if (rb_addr == LAST_ADDR) rb_active <= 1'b0;
            rb_addr <= rb_addr + 1'b1;
        end
    end

    assign m_valid = rb_active;
    assign m_last  = rb_active && (rb_addr == LAST_ADDR);
`endif

    lut_neuron_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (tbl_we),
        .waddr  (wr_addr),
        .wdata  (s_data),
        .rd_en  (armed && lk_valid),
        .rd_clr (!armed),
        .raddr  (lk_addr),
        .rdata  (out_data)
`ifdef LUT_TABLE_READBACK_EN
        ,
        .rb_addr (rb_addr),
        .rb_data (m_data)
`endif
    );

endmodule
